// File: rtl/mandelbrot_pixel_writer_pkg.sv
// mandelbrot_pixel_writer_pkg: shared writer FSM state encoding and pixel width
package mandelbrot_pixel_writer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PTR_RST = 2'd1, STREAM = 2'd2, DONE = 2'd3} state_t;
  localparam int PIXEL_W = 4;
endpackage

// File: rtl/mandelbrot_pixel_writer_pixel_fifo.sv
// pixel_fifo: synchronous FIFO with wrap-bit pointers; push/din in, pop/dout out (head while non-empty), full/empty flags
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_pop, do_push;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(do_push);
      rd_q <= rd_q + (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/mandelbrot_pixel_writer.sv
// mandelbrot_pixel_writer: buffers engine pixels (pixel_in/valid/ready) and writes one frame to the framebuffer (write_mode, reset_write_ptr, write_data/_in, wrote_data ack); start in, busy/frame_done out
module mandelbrot_pixel_writer
  import mandelbrot_pixel_writer_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int FIFO_DEPTH   = 4,
  parameter int PIXEL_CTR_W  = $clog2(FRAME_WIDTH*FRAME_HEIGHT+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PIXEL_W-1:0] pixel_in,
  input  logic               pixel_valid,
  output logic               pixel_ready,
  output logic               write_mode,
  output logic               reset_write_ptr,
  output logic [PIXEL_W-1:0] write_data_in,
  output logic               write_data,
  input  logic               wrote_data,
  output logic               busy,
  output logic               frame_done
);
  localparam logic [PIXEL_CTR_W-1:0] N = PIXEL_CTR_W'(FRAME_WIDTH*FRAME_HEIGHT);
  localparam logic [PIXEL_CTR_W-1:0] ONE = PIXEL_CTR_W'(1);
  state_t state_q;
  logic [PIXEL_CTR_W-1:0] acc_q, wr_cnt_q;
  logic write_data_q, ack_q;
  logic [PIXEL_W-1:0] data_q, head;
  logic push, pop, ack, full, empty;
  assign pixel_ready = (state_q == STREAM) && !full && (acc_q < N);
  assign push = pixel_valid && pixel_ready;
  assign ack = write_data_q && wrote_data;
  // ack_q blocks a pop in the cycle right after an ack, giving the 3-cycle request cadence
  assign pop = (state_q == STREAM) && !write_data_q && !empty && !ack_q;
  assign write_mode = (state_q == PTR_RST) || (state_q == STREAM);
  assign busy = write_mode;
  assign reset_write_ptr = state_q == PTR_RST;
  assign frame_done = state_q == DONE;
  assign write_data = write_data_q;
  assign write_data_in = data_q;
  pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PIXEL_W)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .din(pixel_in),
    .pop(pop), .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      wr_cnt_q <= '0;
      write_data_q <= 1'b0;
      data_q <= '0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack;
      case (state_q)
        IDLE: state_q <= start ? PTR_RST : IDLE;
        PTR_RST: begin
          acc_q <= '0;
          wr_cnt_q <= '0;
          write_data_q <= 1'b0;
          state_q <= STREAM;
        end
        STREAM: begin
          if (push) acc_q <= acc_q + ONE;
          if (pop) begin
            write_data_q <= 1'b1;
            data_q <= head;
          end else if (ack) begin
            write_data_q <= 1'b0;
            wr_cnt_q <= wr_cnt_q + ONE;
            if (wr_cnt_q == N - ONE) state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
